mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the data-memory interface in the MA stage. Takes load/store requests from the EX/MA pipeline register and encodes them into the `data_memory` `read`/`write` command codes. Holds each command across the memory's `busywait` handshake while stalling the pipeline. Aligns and sign- or zero-extends load data, and rejects misaligned accesses without touching memory.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64, maximum ACCESS cycles before abort. Used only with the timeout feature.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `mem_read_in`  in  1  load request from the pipeline.
- `mem_write_in`  in  1  store request from the pipeline. Never high together with `mem_read_in`.
- `funct3_in`  in  3  RV32 load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `address_in`  in  32  effective byte address from the ALU.
- `store_data_in`  in  32  rs2 value.
- `read`  out  4  to memory: {enable, funct3}.
- `write`  out  3  to memory: {enable, funct3[1:0]}.
- `address`  out  32  to memory: registered request address.
- `writedata`  out  32  to memory: registered rs2.
- `readdata`  in  32  from memory: raw aligned word containing the target bytes.
- `busywait`  in  1  from memory. High while an access is in progress.
- `stall`  out  1  to the hazard unit: freeze IF..MA.
- `load_data`  out  32  extended load result to MA/WB.
- `misaligned`  out  1  one-cycle exception pulse.
- `bus_error`  out  1  one-cycle timeout pulse. Tied 0 when the timeout feature is compiled out.

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- **IDLE**
  - A request is `mem_read_in | mem_write_in`.
  - An aligned request latches address, data, funct3 and direction into registers, then moves to ACCESS.
  - A misaligned request moves to DONE with the misaligned flag set. No command is issued.
  - Misaligned means: halfword with `address_in[0]`=1, or word with `address_in[1:0]`≠0. Byte accesses are never misaligned.
- **ACCESS**
  - `read` or `write` is driven from the registers. All other command bits are 0.
  - Memory asserts `busywait` combinationally in response to the command.
  - If `busywait`=0 at a rising edge: capture `readdata` through the aligner into `load_data`, drop the command, and go to DONE.
- **DONE**
  - Lasts exactly one cycle, with `stall`=0. The pipeline advances at the end of this cycle.
  - Next state is always IDLE. Requests are not accepted in DONE.
- **Stall**
  - `stall` = (IDLE and request) or ACCESS.
- **Aligner** (byte offset = `address[1:0]`)
  - LB/LBU select byte `readdata[8*off+7:8*off]`.
  - LH/LHU select halfword `off[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Stores**
  - `load_data` is unchanged.
  - `writedata` is rs2 unmodified. Memory selects lanes from `write[1:0]` and `address[1:0]`.
- **Misaligned**
  - `misaligned`=1 in DONE; `load_data`=0.

## Timing
- Reset values: `read`=0, `write`=0, `address`=0, `writedata`=0, `load_data`=0, `stall`=0, `misaligned`=0, `bus_error`=0, state=IDLE, timeout counter=0.
- Latency: request seen in cycle 0 → command on the bus in cycles 1..N (while `busywait`=1) → DONE in cycle N+1.
  - Zero-wait memory gives N=1.
  - Minimum 3 cycles from request to pipeline advance.
- The command stays constant for all of ACCESS. It deasserts in the same edge that moves the FSM to DONE, so the memory never sees a repeated access.
- `load_data` is stable from DONE until the next load completes.
- `reset` asserted mid-ACCESS: all outputs clear asynchronously and the transaction is abandoned. The memory sees the command drop without completion.
- Request inputs changing during ACCESS are ignored because the values are registered.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter increments each ACCESS cycle.
  - On reaching `TIMEOUT_CYCLES` with `busywait` still 1: drop the command, go to DONE, pulse `bus_error`, and set `load_data`=0.
  - The counter clears on leaving ACCESS.
- Undefined: no counter, `bus_error` is tied 0, and ACCESS waits indefinitely.

## Structure
- Shared package `rv32_mem_pkg`: funct3 constants (LB..LHU, SB..SW), FSM state encoding, and the read/write command-enable bit positions. `data_memory` uses the same encodings.
- One combinational sub-module, `load_aligner`: (funct3, offset, word) → 32-bit extended result.

## Test plan
- Memory model with 3-cycle `busywait`. SW 0xAABBCCDD to 0x04, then LW 0x04 → `write`=3'b110 for 3 cycles; `load_data`=0xAABBCCDD in DONE; `stall` high for 4 cycles.
- With 0xAABBCCDD at word 0x04:
  - LB 0x07 → 0xFFFFFFAA.
  - LBU 0x06 → 0x000000BB.
  - LH 0x06 → 0xFFFFAABB.
  - LHU 0x04 → 0x0000CCDD.
- LW 0x0A and SH 0x05 → `misaligned` pulses 1 cycle; `read`/`write` never leave 0; `load_data`=0.
- Zero-wait memory with back-to-back loads → each takes exactly 3 cycles; exactly one read command interval per load.
- `reset` driven low in the 2nd ACCESS cycle → `read`=0 and `stall`=0 immediately. After release, state is IDLE and the next LW completes normally.
- `MEM_ACCESS_TIMEOUT_EN` with `TIMEOUT_CYCLES`=8 and `busywait` stuck at 1 → command drops after 8 ACCESS cycles; `bus_error` pulses once; `stall` falls in DONE.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared load/store encodings for the MA-stage initiator and data_memory:
// funct3 codes, FSM state encoding and command-enable bit positions.
package rv32_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int READ_EN_BIT  = 3;
   localparam int WRITE_EN_BIT = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } mau_state_t;

   // size is funct3[1:0]: 00 byte, 01 halfword, 10 word
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/halfword from a raw memory word and
// sign- or zero-extends it according to the load funct3.
module load_aligner
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{offset, 3'b000} +: 8];
      half_sel = offset[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {24'd0, byte_sel};
         F3_LHU:  result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MA-stage data-memory initiator: registers a load/store, holds the command
// across busywait, stalls the pipeline and aligns load data.
// Optional watchdog on ACCESS enabled by defining MEM_ACCESS_TIMEOUT_EN.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for a request; misaligned requests skip to DONE
//   ST_ACCESS | command on the bus until busywait drops (or watchdog fires)
//   ST_DONE   | one unstalled cycle so the pipeline advances; no requests
module mem_access_unit
   import rv32_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] address_in,
   input  logic [31:0] store_data_in,
   output logic [3:0]  read,
   output logic [2:0]  write,
   output logic [31:0] address,
   output logic [31:0] writedata,
   input  logic [31:0] readdata,
   input  logic        busywait,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_error
);

   mau_state_t  state_q, state_d;
   logic [31:0] addr_q, wdata_q, load_q;
   logic [2:0]  f3_q;
   logic        is_read_q, mis_q;
   logic        req, mis_req, access_timeout;
   logic [31:0] aligned;

   assign req     = mem_read_in | mem_write_in;
   assign mis_req = is_misaligned(funct3_in[1:0], address_in[1:0]);

   load_aligner u_load_aligner (
      .funct3 (f3_q),
      .offset (addr_q[1:0]),
      .word   (readdata),
      .result (aligned)
   );

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q;
   logic             berr_q;

   // cnt_q holds the number of ACCESS cycles already completed
   assign access_timeout = (state_q == ST_ACCESS) && busywait
                           && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         berr_q <= 1'b0;
      end else begin
         berr_q <= access_timeout;
         if (state_q == ST_ACCESS && state_d == ST_ACCESS) cnt_q <= cnt_q + 1'b1;
         else                                               cnt_q <= '0;
      end
   end

   assign bus_error = berr_q;
`else
   assign access_timeout = 1'b0;
   assign bus_error      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      read    = '0;
      write   = '0;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // gated by reset so the hazard unit is released while reset is held
            stall = req & reset;
            if (req) state_d = mis_req ? ST_DONE : ST_ACCESS;
         end
         ST_ACCESS: begin
            stall = 1'b1;
            if (is_read_q) begin
               read[READ_EN_BIT] = 1'b1;
               read[2:0]         = f3_q;
            end else begin
               write[WRITE_EN_BIT] = 1'b1;
               write[1:0]          = f3_q[1:0];
            end
            if (!busywait || access_timeout) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         load_q    <= '0;
         f3_q      <= '0;
         is_read_q <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         mis_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req && mis_req) begin
                  mis_q  <= 1'b1;
                  load_q <= '0;
               end else if (req) begin
                  addr_q    <= address_in;
                  wdata_q   <= store_data_in;
                  f3_q      <= funct3_in;
                  is_read_q <= mem_read_in;
               end
            end
            ST_ACCESS: begin
               if (access_timeout)              load_q <= '0;
               else if (!busywait && is_read_q) load_q <= aligned;
            end
            default: ;
         endcase
      end
   end

   assign address    = addr_q;
   assign writedata  = wdata_q;
   assign load_data  = load_q;
   assign misaligned = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural data memory with a
// programmable busywait length plus a word-array reference model.
module tb_mem_access_unit;
   import rv32_mem_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
   logic [2:0]  funct3_in = '0;
   logic [31:0] address_in = '0, store_data_in = '0;
   logic [3:0]  read;
   logic [2:0]  write;
   logic [31:0] address, writedata, readdata, load_data;
   logic        busywait, stall, misaligned, bus_error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .mem_read_in   (mem_read_in),
      .mem_write_in  (mem_write_in),
      .funct3_in     (funct3_in),
      .address_in    (address_in),
      .store_data_in (store_data_in),
      .read          (read),
      .write         (write),
      .address       (address),
      .writedata     (writedata),
      .readdata      (readdata),
      .busywait      (busywait),
      .stall         (stall),
      .load_data     (load_data),
      .misaligned    (misaligned),
      .bus_error     (bus_error)
   );

   // memory: command lasts wait_cycles cycles, or forever when stuck_busy
   int          wait_cycles = 1;
   bit          stuck_busy  = 1'b0;
   bit          mem_clear   = 1'b1;
   int          mem_cnt     = 0;
   logic [31:0] dmem [16];
   logic        cmd_active;

   assign cmd_active = read[3] | write[2];
   assign readdata   = dmem[address[5:2]];
   always_comb busywait = cmd_active && (stuck_busy || (mem_cnt < wait_cycles - 1));

   always @(posedge clock) begin
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) dmem[i] <= '0;
      end else if (write[2] && !busywait) begin
         case (write[1:0])
            2'b00:   dmem[address[5:2]][{address[1:0], 3'b000} +: 8]  <= writedata[7:0];
            2'b01:   dmem[address[5:2]][{address[1], 4'b0000} +: 16] <= writedata[15:0];
            default: dmem[address[5:2]] <= writedata;
         endcase
      end
      mem_cnt <= (cmd_active && busywait) ? mem_cnt + 1 : 0;
   end

   // reference model
   logic [31:0] ref_mem [16];
   logic [31:0] last_ld = '0;

   function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
      int sz, off;
      sz  = int'(f3) % 4;
      off = int'(a % 4);
      return (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w, b, h;
      int off;
      w   = ref_mem[int'(a / 4) % 16];
      off = int'(a % 4);
      b   = (w >> (8 * off)) & 32'hFF;
      h   = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         F3_LB:   return (b >= 128) ? b - 32'd256 : b;
         F3_LH:   return (h >= 32768) ? h - 32'd65536 : h;
         F3_LBU:  return b;
         F3_LHU:  return h;
         default: return w;
      endcase
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] mask, val;
      int off, idx;
      off = int'(a % 4);
      idx = int'(a / 4) % 16;
      case (f3)
         F3_SB: begin mask = 32'hFF << (8 * off); val = (d & 32'hFF) << (8 * off); end
         F3_SH: begin mask = 32'hFFFF << (16 * (off / 2)); val = (d & 32'hFFFF) << (16 * (off / 2)); end
         default: begin mask = 32'hFFFF_FFFF; val = d; end
      endcase
      ref_mem[idx] = (ref_mem[idx] & ~mask) | val;
   endtask

   // observations of one transaction
   int          n_acc;
   bit          stall0, cmd_bad, done_clr, tmo;
   logic [3:0]  rd_seen;
   logic [2:0]  wr_seen;
   logic [31:0] addr_seen, wd_seen, ld;
   logic        mis, berr;

   task automatic run_txn(input bit is_ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
      @(negedge clock);
      mem_read_in   = is_ld;
      mem_write_in  = !is_ld;
      funct3_in     = f3;
      address_in    = a;
      store_data_in = d;
      #1;
      stall0   = stall;
      cmd_bad  = (read != 4'd0) || (write != 3'd0);
      n_acc    = 0;
      tmo      = 1'b1;
      done_clr = 1'b0;
      rd_seen  = '0; wr_seen = '0; addr_seen = '0; wd_seen = '0;
      ld = 'x; mis = 1'bx; berr = 1'bx;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         #1;
         if (!stall) begin
            tmo      = 1'b0;
            done_clr = (read == 4'd0) && (write == 3'd0);
            ld       = load_data;
            mis      = misaligned;
            berr     = bus_error;
            break;
         end
         if (n_acc == 0) begin
            rd_seen = read; wr_seen = write; addr_seen = address; wd_seen = writedata;
         end else if (read !== rd_seen || write !== wr_seen || address !== addr_seen
                      || writedata !== wd_seen) begin
            cmd_bad = 1'b1;
         end
         n_acc++;
         // the pipeline register may change underneath a held command
         address_in    = $urandom;
         store_data_in = $urandom;
         funct3_in     = 3'($urandom_range(0, 7));
      end
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
      n_checks++;
      if (tmo) begin
         n_fail++;
         $display("FAIL txn_timeout: no DONE within 40 cycles (addr=%h)", a);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({read, write} !== 7'd0) begin
         n_fail++; $display("FAIL reset_cmd: read=%b write=%b, need 0", read, write);
      end
      n_checks++;
      if ({address, writedata, load_data} !== 96'd0) begin
         n_fail++; $display("FAIL reset_regs: address=%h writedata=%h load_data=%h, need 0",
                            address, writedata, load_data);
      end
      n_checks++;
      if ({stall, misaligned, bus_error} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: stall=%b mis=%b berr=%b, need 000",
                            stall, misaligned, bus_error);
      end
   endtask

   task automatic test_spec_example();
      wait_cycles = 3;
      run_txn(1'b0, F3_SW, 32'h04, 32'hAABBCCDD);
      ref_store(F3_SW, 32'h04, 32'hAABBCCDD);
      n_checks++;
      if (wr_seen !== 3'b110 || rd_seen !== 4'd0 || cmd_bad) begin
         n_fail++; $display("FAIL sw_cmd: write=%b read=%b bad=%0d, need write=110", wr_seen, rd_seen, cmd_bad);
      end
      n_checks++;
      if (!stall0 || n_acc != 3) begin
         n_fail++; $display("FAIL sw_stall: stall cycles=%0d, need 4", (stall0 ? 1 : 0) + n_acc);
      end
      n_checks++;
      if (ld !== last_ld || !done_clr) begin
         n_fail++; $display("FAIL sw_done: load_data=%h clr=%0d, need %h", ld, done_clr, last_ld);
      end
      run_txn(1'b1, F3_LW, 32'h04, 32'h0);
      n_checks++;
      if (rd_seen !== 4'b1010 || n_acc != 3 || ld !== 32'hAABBCCDD) begin
         n_fail++; $display("FAIL lw_example: read=%b acc=%0d load_data=%h, need 1010/3/aabbccdd",
                            rd_seen, n_acc, ld);
      end
      last_ld = ld;
   endtask

   task automatic test_aligner();
      logic [2:0]  f3s  [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
      logic [31:0] adrs [4] = '{32'h07, 32'h06, 32'h06, 32'h04};
      logic [31:0] exps [4] = '{32'hFFFFFFAA, 32'h000000BB, 32'hFFFFAABB, 32'h0000CCDD};
      wait_cycles = 2;
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, f3s[i], adrs[i], 32'h0);
         n_checks++;
         if (ld !== exps[i] || rd_seen !== {1'b1, f3s[i]}) begin
            n_fail++; $display("FAIL aligner_%0d: load_data=%h read=%b, need %h", i, ld, rd_seen, exps[i]);
         end
         last_ld = ld;
      end
   endtask

   task automatic test_misaligned();
      logic [2:0]  f3s  [2] = '{F3_LW, F3_SH};
      logic [31:0] adrs [2] = '{32'h0A, 32'h05};
      bit          lds  [2] = '{1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         run_txn(lds[i], f3s[i], adrs[i], 32'h1234_5678);
         n_checks++;
         if (mis !== 1'b1 || n_acc != 0 || cmd_bad || !done_clr || !stall0) begin
            n_fail++; $display("FAIL misaligned_%0d: mis=%b acc=%0d bad=%0d stall0=%0d, need 1/0/0/1",
                               i, mis, n_acc, cmd_bad, stall0);
         end
         n_checks++;
         if (ld !== 32'd0) begin
            n_fail++; $display("FAIL misaligned_ld_%0d: load_data=%h, need 0", i, ld);
         end
         @(negedge clock);
         #1;
         n_checks++;
         if (misaligned !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_pulse_%0d: mis=%b after DONE, need 0", i, misaligned);
         end
      end
      last_ld = '0;
   endtask

   task automatic test_back_to_back();
      time t_prev, t_now;
      logic [31:0] a;
      wait_cycles = 1;
      for (int i = 0; i < 4; i++) begin
         a = 32'($urandom_range(0, 15)) * 4;
         run_txn(1'b1, F3_LW, a, 32'h0);
         t_now = $time;
         n_checks++;
         if (n_acc != 1 || ld !== ref_load(F3_LW, a) || !stall0) begin
            n_fail++; $display("FAIL b2b_%0d: acc=%0d load_data=%h, need 1/%h", i, n_acc, ld, ref_load(F3_LW, a));
         end
         if (i > 0) begin
            n_checks++;
            if (t_now - t_prev != 30) begin
               n_fail++; $display("FAIL b2b_spacing_%0d: %0t between loads, need 30", i, t_now - t_prev);
            end
         end
         t_prev  = t_now;
         last_ld = ld;
      end
   endtask

   task automatic test_random();
      logic [2:0]  ld_ops [5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
      logic [2:0]  st_ops [3] = '{F3_SB, F3_SH, F3_SW};
      bit          is_ld, m;
      logic [2:0]  f3;
      logic [31:0] a, d, exp_ld;
      int          exp_acc;
      for (int i = 0; i < 60; i++) begin
         is_ld       = 1'($urandom_range(0, 1));
         f3          = is_ld ? ld_ops[$urandom_range(0, 4)] : st_ops[$urandom_range(0, 2)];
         a           = 32'($urandom_range(0, 63));
         d           = $urandom;
         wait_cycles = $urandom_range(1, 4);
         m           = ref_mis(f3, a);
         exp_acc     = m ? 0 : wait_cycles;
         if (m)          exp_ld = '0;
         else if (is_ld) exp_ld = ref_load(f3, a);
         else            exp_ld = last_ld;
         run_txn(is_ld, f3, a, d);
         if (!is_ld && !m) ref_store(f3, a, d);
         n_checks++;
         if (ld !== exp_ld || mis !== m || berr !== 1'b0) begin
            n_fail++; $display("FAIL rand_%0d_result: f3=%0d a=%h load_data=%h mis=%b berr=%b, need %h/%b/0",
                               i, f3, a, ld, mis, berr, exp_ld, m);
         end
         n_checks++;
         if (n_acc != exp_acc || cmd_bad || !done_clr || !stall0) begin
            n_fail++; $display("FAIL rand_%0d_timing: acc=%0d bad=%0d clr=%0d, need acc=%0d",
                               i, n_acc, cmd_bad, done_clr, exp_acc);
         end
         if (!m) begin
            n_checks++;
            if (rd_seen !== (is_ld ? {1'b1, f3} : 4'd0) || wr_seen !== (is_ld ? 3'd0 : {1'b1, f3[1:0]})
                || addr_seen !== a || wd_seen !== d) begin
               n_fail++; $display("FAIL rand_%0d_cmd: read=%b write=%b addr=%h wdata=%h, need addr=%h wdata=%h",
                                  i, rd_seen, wr_seen, addr_seen, wd_seen, a, d);
            end
         end
         last_ld = ld;
      end
   endtask

   task automatic test_reset_mid_access();
      wait_cycles = 5;
      @(negedge clock);
      mem_read_in = 1'b1; funct3_in = F3_LW; address_in = 32'h08;
      @(negedge clock);
      @(negedge clock);
      #1;
      n_checks++;
      if (read !== 4'b1010) begin
         n_fail++; $display("FAIL rst_pre: read=%b in 2nd ACCESS cycle, need 1010", read);
      end
      reset = 1'b0;
      #1;
      n_checks++;
      if (read !== 4'd0 || stall !== 1'b0 || address !== 32'd0 || load_data !== 32'd0) begin
         n_fail++; $display("FAIL rst_async: read=%b stall=%b addr=%h load_data=%h, need all 0",
                            read, stall, address, load_data);
      end
      @(negedge clock);
      mem_read_in = 1'b0;
      reset = 1'b1;
      last_ld = '0;
      wait_cycles = 2;
      run_txn(1'b1, F3_LW, 32'h08, 32'h0);
      n_checks++;
      if (n_acc != 2 || ld !== ref_load(F3_LW, 32'h08) || cmd_bad) begin
         n_fail++; $display("FAIL rst_recover: acc=%0d load_data=%h, need 2/%h", n_acc, ld, ref_load(F3_LW, 32'h08));
      end
      last_ld = ld;
   endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
   task automatic test_timeout();
      stuck_busy = 1'b1;
      run_txn(1'b1, F3_LW, 32'h04, 32'h0);
      stuck_busy = 1'b0;
      n_checks++;
      if (n_acc != 8 || berr !== 1'b1 || ld !== 32'd0 || !done_clr) begin
         n_fail++; $display("FAIL timeout: acc=%0d berr=%b load_data=%h clr=%0d, need 8/1/0/1",
                            n_acc, berr, ld, done_clr);
      end
      @(negedge clock);
      #1;
      n_checks++;
      if (bus_error !== 1'b0) begin
         n_fail++; $display("FAIL timeout_pulse: bus_error=%b after DONE, need 0", bus_error);
      end
      last_ld = '0;
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      repeat (3) @(negedge clock);
      test_reset();
      mem_clear = 1'b0;
      reset     = 1'b1;
      test_spec_example();
      test_aligner();
      test_misaligned();
      test_back_to_back();
      test_random();
      test_reset_mid_access();
`ifdef MEM_ACCESS_TIMEOUT_EN
      test_timeout();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
